// File: rtl/bit_count_ctrl.sv
// Control FSM for the bit-counting datapath: load, shift until zero, drain one cycle, capture count.
// Strobes decode from state (EA Mealy on z, LA Mealy on s) and are held low while rst is asserted.
module bit_count_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s,
  input  logic          z,
  input  logic          a0,
  input  logic [CW-1:0] B_in,
  output logic          LA,
  output logic          EA,
  output logic          LB,
  output logic          EB,
  output logic          w,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] result
);

  localparam int SCW = $clog2(WIDTH + 2);

  typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, CAPTURE, DONE} state_t;

  state_t         state;
  logic [SCW-1:0] shift_cnt;
  logic           first;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      result    <= '0;
      err       <= 1'b0;
      shift_cnt <= '0;
      first     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s) begin
            state     <= SHIFT;
            shift_cnt <= '0;
            first     <= 1'b1;
          end
        end
        SHIFT: begin
          first <= 1'b0;
          if (!z) shift_cnt <= shift_cnt + 1'b1;
          // WIDTH+1 shifts without the register emptying means z is stuck
          if (z) begin
            state <= DRAIN;
          end else if (shift_cnt == SCW'(WIDTH)) begin
            err   <= 1'b1;
            state <= CAPTURE;
          end
        end
        DRAIN:   state <= CAPTURE;
        CAPTURE: begin
          result <= B_in;
          state  <= DONE;
        end
        DONE: begin
          if (!s) begin
            state <= IDLE;
            err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    LA   = 1'b0;
    EA   = 1'b0;
    LB   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    begin LA = ~s;  LB = 1'b1;   end
        SHIFT:   begin EA = ~z;  busy = 1'b1; end
        DRAIN:   begin EA = 1'b1; busy = 1'b1; end
        CAPTURE: busy = 1'b1;
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

  // a0 is stale on the first shift of an operation
  assign EB = EA & a0 & ~first;
  assign w  = 1'b0;

endmodule

// File: doc/bit_count_ctrl.md
Name: bit_count_ctrl

Overview:
- Control FSM for the bit-counting datapath. It sits directly upstream of the shift-register/counter datapath and drives that datapath's load, shift and clear strobes.
- It sequences load → shift-until-zero → drain → capture, then presents a latched ones-count with a start/done handshake to the surrounding logic.
- It consumes the datapath's zero flag (z), shifted-out bit (a0) and count (B).

Parameters:
- WIDTH, 4: data width of the datapath shift register; bounds the legal number of shift cycles.
- CW, 3: width of the count bus and of the result register (must satisfy 2^CW > WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- s  input  1  start/hold request from the host.
- z  input  1  datapath flag: shift register contents == 0.
- a0  input  1  datapath registered shift-out bit.
- B_in  input  CW  datapath count value.
- LA  output  1  load shift register from Data.
- EA  output  1  shift-enable to the datapath.
- LB  output  1  clear count.
- EB  output  1  count-enable (qualified a0).
- w  output  1  serial fill bit into the shift-register MSB; constant 0.
- busy  output  1  high in SHIFT, DRAIN and CAPTURE.
- done  output  1  result valid; held high until s falls.
- err  output  1  timeout flag; valid while done is high.
- result  output  CW  latched ones-count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low. On reset: state=IDLE; result=0, err=0, shift_cnt=0, first=0.
- After reset release, outputs take their IDLE decode values (LA=~s, LB=1, all others 0).
- States: IDLE, SHIFT, DRAIN, CAPTURE, DONE. Encoding is free. All outputs are registered-state decodes except the Mealy terms noted below.
- IDLE:
  - LB=1; LA=~s, so Data reloads every cycle while s=0.
  - When s=1: LA=0; next state SHIFT; shift_cnt<=0; first<=1.
- SHIFT:
  - EA = ~z (Mealy on z); shift_cnt increments on each EA cycle; first<=0 after the first cycle.
  - If z=1: next state DRAIN.
  - Else if shift_cnt==WIDTH (i.e. WIDTH+1 shifts without z): err<=1, next state CAPTURE.
  - Else stay in SHIFT.
- DRAIN: EA=1 for exactly one cycle so the last registered a0 is counted; next state CAPTURE.
- CAPTURE: result<=B_in; next state DONE.
- DONE:
  - done=1; all strobes 0.
  - Stay while s=1; on s=0, next state IDLE, and err clears on that transition.
- EB = EA & a0 & ~first. The first-shift cycle is suppressed so a stale a0 is never counted.
- w is always 0.
- Latency: let n = index of the highest set bit of Data + 1 (n=0 for Data=0). SHIFT lasts n+1 cycles; done rises n+3 cycles after the clk edge that enters SHIFT.
- s falling during SHIFT, DRAIN or CAPTURE is ignored; the operation completes. s=0 already present at DONE entry gives a 1-cycle done pulse.
- Reset mid-operation: immediate return to IDLE; result and err clear; no strobes asserted during reset.
- result is stable outside CAPTURE. It is not cleared on return to IDLE and holds the last count until the next CAPTURE.

Test Plan:
- Reset, then Data=4'b1011, s held high: SHIFT lasts 5 cycles (EA high for 4), DRAIN 1 cycle, done rises 7 cycles after SHIFT entry, result=3, err=0.
- Data=4'b0000, s=1: EA never asserted in SHIFT (z=1); DRAIN once; done 3 cycles after SHIFT entry; result=0.
- Data=4'b1111: EB high on exactly 4 cycles, with the first EA cycle's EB=0; result=4. Then s=0 → IDLE, LA=1, LB=1, done=0.
- z forced to 0 permanently: after 5 SHIFT cycles err=1, CAPTURE, done=1, err cleared on s=0.
- rst asserted low mid-SHIFT (Data=4'b1000, 2nd shift): outputs drop immediately to reset values; after release, restart with s=1 gives result=1.
- s toggled 1→0 during SHIFT: operation still completes with correct result; done is a single-cycle pulse followed by IDLE.
